// File: rtl/sub_serial_pkg.sv
// sub_serial shared types and constants.
// State encodings, default operand masks.
package sub_serial_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB  = 3'd1,
    DONE = 3'd2,
    DLY0 = 3'd3,
    DLY1 = 3'd4,
    DLY2 = 3'd5,
    DLY3 = 3'd6
  } state_t;

  localparam logic [7:0] A_MASK_DEF = 8'hB3;
  localparam logic [7:0] B_MASK_DEF = 8'h2A;

endpackage

// File: rtl/sub_serial_if.sv
// sub_serial operand/result bus.
// master drives operands, slave returns the difference.
interface sub_serial_if #(
  parameter int W = 8
);

  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         borrow_out;
  logic         done;

  modport master (
    output en, a, b,
    input  out, borrow_out, done
  );

  modport slave (
    input  en, a, b,
    output out, borrow_out, done
  );

endinterface

// File: rtl/sub_serial_full_sub.sv
// One-bit full subtractor cell.
// d = ab - bb - bin, bout set on underflow.
module serial_full_sub (
  input  logic ab,
  input  logic bb,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ab ^ bb ^ bin;
  assign bout = (~ab & bb) | (~(ab ^ bb) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor with masked operand storage.
// Decoy states fall back to IDLE without touching the datapath.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int           W      = 8,
  parameter logic [W-1:0] A_MASK = W'(A_MASK_DEF),
  parameter logic [W-1:0] B_MASK = W'(B_MASK_DEF)
) (
  input logic         clk,
  input logic         rst,
  sub_serial_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state, state_d;
  logic [W-1:0]   a_reg, a_d;
  logic [W-1:0]   b_reg, b_d;
  logic [CW-1:0]  count, count_d;
  logic           borrow, borrow_d;
  logic [W-1:0]   out_q, out_d;
  logic           bo_q, bo_d;
  logic           done_q, done_d;

  logic ab, bb, d, bout;

  // Stored bits are masked; strip the mask bit that matches this position.
  assign ab = a_reg[0] ^ A_MASK[count];
  assign bb = b_reg[0] ^ B_MASK[count];

  serial_full_sub u_fs (
    .ab   (ab),
    .bb   (bb),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  always_comb begin
    state_d  = state;
    a_d      = a_reg;
    b_d      = b_reg;
    count_d  = count;
    borrow_d = borrow;
    out_d    = out_q;
    bo_d     = bo_q;
    done_d   = done_q;
    unique case (state)
      IDLE: begin
        if (bus.en) begin
          a_d      = bus.a ^ A_MASK;
          b_d      = bus.b ^ B_MASK;
          count_d  = '0;
          borrow_d = 1'b0;
          out_d    = '0;
          bo_d     = 1'b0;
          state_d  = SUB;
        end
      end
      SUB: begin
        borrow_d = bout;
        out_d    = {d, out_q[W-1:1]};
        a_d      = a_reg >> 1;
        b_d      = b_reg >> 1;
        count_d  = count + 1'b1;
        if (count == CW'(W - 1)) begin
          bo_d    = bout;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      count  <= '0;
      borrow <= 1'b0;
      out_q  <= '0;
      bo_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      a_reg  <= a_d;
      b_reg  <= b_d;
      count  <= count_d;
      borrow <= borrow_d;
      out_q  <= out_d;
      bo_q   <= bo_d;
      done_q <= done_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.borrow_out = bo_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial.
// Default-mask and zero-mask instances run in lockstep.
module tb_sub_serial;
  import sub_serial_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a, b;
  int         checks;
  int         errors;

  sub_serial_if #(.W(8)) bus ();
  sub_serial_if #(.W(8)) bus0 ();

  assign bus.en  = en;
  assign bus.a   = a;
  assign bus.b   = b;
  assign bus0.en = en;
  assign bus0.a  = a;
  assign bus0.b  = b;

  sub_serial #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  sub_serial #(
    .W      (8),
    .A_MASK (8'h00),
    .B_MASK (8'h00)
  ) m0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       output int lat, output logic [7:0] acc_out);
    @(negedge clk);
    a  = x;
    b  = y;
    en = 1'b1;
    @(negedge clk);
    en      = 1'b0;
    acc_out = bus.out;
    lat     = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    #12;
    checks++;
    if (bus.out !== 8'h00 || bus.borrow_out !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got out=%h bo=%b done=%b want 00 0 0",
               bus.out, bus.borrow_out, bus.done);
    end
    checks++;
    if (dut.state !== IDLE || m0.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d want 0", dut.state, m0.state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] acc;
    do_op(8'h05, 8'h03, lat, acc);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency got %0d want 8", lat);
    end
    checks++;
    if (bus0.out !== 8'h02 || bus0.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_m0 got %h/%b want 02/0", bus0.out, bus0.borrow_out);
    end
    checks++;
    if (bus.out !== 8'h02 || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_dut got %h/%b want 02/0", bus.out, bus.borrow_out);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.out !== 8'h02 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL basic_after got done=%b out=%h st=%0d want 0 02 0",
               bus.done, bus.out, dut.state);
    end
  endtask

  task automatic test_negative();
    int lat;
    logic [7:0] acc;
    do_op(8'h03, 8'h05, lat, acc);
    checks++;
    if (acc !== 8'h00) begin
      errors++;
      $display("FAIL neg_accept_out got %h want 00", acc);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL neg_latency got %0d want 8", lat);
    end
    checks++;
    if (bus.out !== 8'hFE || bus.borrow_out !== 1'b1) begin
      errors++;
      $display("FAIL neg_dut got %h/%b want FE/1", bus.out, bus.borrow_out);
    end
  endtask

  task automatic test_mask();
    int lat;
    logic [7:0] acc;
    do_op(8'hA7, 8'h5C, lat, acc);
    checks++;
    if (bus.out !== 8'h4B || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL mask_dut got %h/%b want 4B/0", bus.out, bus.borrow_out);
    end
    checks++;
    if (bus0.out !== 8'h4B || bus0.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL mask_m0 got %h/%b want 4B/0", bus0.out, bus0.borrow_out);
    end
  endtask

  task automatic test_isolation();
    int lat;
    @(negedge clk);
    a  = 8'h00;
    b  = 8'h01;
    en = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a = ~a;
      b = b + 8'h37;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL iso_latency got %0d want 9", lat);
    end
    checks++;
    if (bus.out !== 8'hFF || bus.borrow_out !== 1'b1) begin
      errors++;
      $display("FAIL iso_dut got %h/%b want FF/1", bus.out, bus.borrow_out);
    end
    a  = 8'h22;
    b  = 8'h11;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || dut.state !== IDLE || bus.out !== 8'hFF) begin
      errors++;
      $display("FAIL iso_pulse got done=%b st=%0d out=%h want 0 0 FF",
               bus.done, dut.state, bus.out);
    end
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (dut.state !== SUB || bus.out !== 8'h00) begin
      errors++;
      $display("FAIL iso_reaccept got st=%0d out=%h want 1 00",
               dut.state, bus.out);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 8 || bus.out !== 8'h11 || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL iso_second got lat=%0d out=%h bo=%b want 8 11 0",
               lat, bus.out, bus.borrow_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] acc;
    @(negedge clk);
    a  = 8'h77;
    b  = 8'h11;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.out !== 8'h60) begin
      errors++;
      $display("FAIL mid_partial got %h want 60", bus.out);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out !== 8'h00 || bus.borrow_out !== 1'b0 ||
        bus.done !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset got out=%h bo=%b done=%b st=%0d want 00 0 0 0",
               bus.out, bus.borrow_out, bus.done, dut.state);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(8'h10, 8'h01, lat, acc);
    checks++;
    if (lat !== 8 || bus.out !== 8'h0F || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got lat=%0d out=%h bo=%b want 8 0F 0",
               lat, bus.out, bus.borrow_out);
    end
  endtask

  task automatic test_decoy();
    logic [7:0] sa, sb, so;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    sa = dut.a_reg;
    sb = dut.b_reg;
    so = bus.out;
    force dut.state = DLY2;
    #1;
    release dut.state;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL decoy_dly2 got st=%0d done=%b want 0 0",
               dut.state, bus.done);
    end
    checks++;
    if (dut.a_reg !== sa || dut.b_reg !== sb || bus.out !== so) begin
      errors++;
      $display("FAIL decoy_dly2_regs got %h %h %h want %h %h %h",
               dut.a_reg, dut.b_reg, bus.out, sa, sb, so);
    end
    force dut.state = state_t'(3'd7);
    #1;
    release dut.state;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL decoy_7 got st=%0d done=%b want 0 0",
               dut.state, bus.done);
    end
    checks++;
    if (dut.a_reg !== sa || dut.b_reg !== sb || bus.out !== so) begin
      errors++;
      $display("FAIL decoy_7_regs got %h %h %h want %h %h %h",
               dut.a_reg, dut.b_reg, bus.out, sa, sb, so);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_negative();
    test_mask();
    test_isolation();
    test_reset_mid();
    test_decoy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
